// File: rtl/tetris_field_renderer.sv
// Pipelined playfield renderer: grid/border region decode, cell + sprite fetch,
// palette/shading, line-clear flash FSM and game-over grey fade. Latency 3 cycles.
module tetris_field_renderer #(
    parameter int BLOCK_SIZE    = 32,
    parameter int FIELD_W       = 10,
    parameter int FIELD_H       = 20,
    parameter int HIDDEN_ROWS   = 2,
    parameter int GRID_X0       = 480,
    parameter int GRID_Y0       = 80,
    parameter int BORDER        = 4,
    parameter int EMPTY_CODE    = 7,
    parameter int FLASH_FRAMES  = 8,
    parameter int FLASH_TOGGLES = 6
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [10:0]                            curr_x,
    input  logic [9:0]                             curr_y,
    input  logic                                   active_area,
    input  logic                                   frame_start,
    output logic [$clog2(FIELD_H+HIDDEN_ROWS)-1:0] cell_row,
    output logic [$clog2(FIELD_W)-1:0]             cell_col,
    input  logic [2:0]                             cell_data,
    output logic [3:0]                             sprite_addr_x,
    output logic [3:0]                             sprite_addr_y,
    input  logic [11:0]                            sprite_pixel,
    input  logic                                   game_over,
    input  logic                                   clear_start,
    input  logic [FIELD_H-1:0]                     clear_rows,
    output logic                                   clear_busy,
    output logic                                   clear_done,
    output logic [3:0]                             vga_r,
    output logic [3:0]                             vga_g,
    output logic [3:0]                             vga_b
);

    localparam int ROW_W   = $clog2(FIELD_H + HIDDEN_ROWS);
    localparam int VROW_W  = $clog2(FIELD_H);
    localparam int LOG2_BS = $clog2(BLOCK_SIZE);
    localparam int FCNT_W  = $clog2(FLASH_FRAMES + 1);
    localparam int TCNT_W  = $clog2(FLASH_TOGGLES + 1);

    localparam logic signed [11:0] X0  = 12'(GRID_X0);
    localparam logic signed [11:0] Y0  = 12'(GRID_Y0);
    localparam logic signed [11:0] GW  = 12'(FIELD_W * BLOCK_SIZE);
    localparam logic signed [11:0] GH  = 12'(FIELD_H * BLOCK_SIZE);
    localparam logic signed [11:0] BRD = 12'(BORDER);
    localparam logic [3:0]         FADE_MAX = 4'd9;

    function automatic logic [11:0] palette(input logic [2:0] code);
        logic [11:0] c;
        case (code)
            3'd0:    c = 12'hF00;
            3'd1:    c = 12'h0F0;
            3'd2:    c = 12'h00F;
            3'd3:    c = 12'hFF0;
            3'd4:    c = 12'hF0F;
            3'd5:    c = 12'h0FF;
            3'd6:    c = 12'hFA0;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

    function automatic logic [11:0] shade(input logic [11:0] c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

    function automatic logic [3:0] fade_step(input logic [3:0] f);
        return (f >= FADE_MAX) ? FADE_MAX : f + 4'd1;
    endfunction

    typedef enum logic [0:0] {IDLE, FLASH} state_t;

    state_t              state;
    logic [FIELD_H-1:0]  row_mask;
    logic                phase;
    logic [FCNT_W-1:0]   frame_cnt;
    logic [TCNT_W-1:0]   toggle_cnt;
    logic [3:0]          fade;

    logic signed [11:0]  rel_x_p0, rel_y_p0;
    logic                in_grid_p0, in_frame_p0;

    logic                vld_p1, cell_p1, border_p1;
    logic [VROW_W-1:0]   vis_row_p1;
    logic                vld_p2, cell_p2, border_p2;
    logic [VROW_W-1:0]   vis_row_p2;

    logic                empty_p2, flash_p2;
    logic [3:0]          grey_p2;
    logic [11:0]         base_p2, colour_p2;

    logic                unused_sprite_bits;
    assign unused_sprite_bits = ^{sprite_pixel[11:8], sprite_pixel[3:0]};

    // Stage 0: signed grid-relative coordinates, so off-grid pixels stay negative
    assign rel_x_p0    = $signed({1'b0, curr_x}) - X0;
    assign rel_y_p0    = $signed({2'b00, curr_y}) - Y0;
    assign in_grid_p0  = (rel_x_p0 >= 12'sd0) && (rel_x_p0 < GW) &&
                         (rel_y_p0 >= 12'sd0) && (rel_y_p0 < GH);
    assign in_frame_p0 = (rel_x_p0 >= -BRD) && (rel_x_p0 < GW + BRD) &&
                         (rel_y_p0 >= -BRD) && (rel_y_p0 < GH + BRD);

    // Stage 1: region flags and cell/sprite addresses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1        <= 1'b0;
            cell_p1       <= 1'b0;
            border_p1     <= 1'b0;
            cell_row      <= '0;
            cell_col      <= '0;
            sprite_addr_x <= '0;
            sprite_addr_y <= '0;
        end else begin
            vld_p1    <= active_area;
            cell_p1   <= active_area && in_grid_p0;
            border_p1 <= active_area && in_frame_p0 && !in_grid_p0;
            if (active_area && in_grid_p0) begin
                cell_row      <= rel_y_p0[LOG2_BS +: ROW_W] + ROW_W'(HIDDEN_ROWS);
                cell_col      <= rel_x_p0[LOG2_BS +: $bits(cell_col)];
                sprite_addr_x <= rel_x_p0[LOG2_BS-1 -: 4];
                sprite_addr_y <= rel_y_p0[LOG2_BS-1 -: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        vis_row_p1 <= rel_y_p0[LOG2_BS +: VROW_W];
        vis_row_p2 <= vis_row_p1;
    end

    // Stage 2: region follows the address while the field/sprite reads complete
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            cell_p2   <= 1'b0;
            border_p2 <= 1'b0;
        end else begin
            vld_p2    <= vld_p1;
            cell_p2   <= cell_p1;
            border_p2 <= border_p1;
        end
    end

    assign empty_p2 = (cell_data == 3'(EMPTY_CODE));
    assign flash_p2 = clear_busy && row_mask[vis_row_p2] && phase;
    assign grey_p2  = 4'hF - fade;

    always_comb begin
        base_p2   = 12'h000;
        colour_p2 = 12'h000;
        if (vld_p2) begin
            if (border_p2) begin
                colour_p2 = 12'hFFF;
            end else if (cell_p2) begin
                if (flash_p2)
                    base_p2 = 12'hFFF;
                else if (empty_p2)
                    base_p2 = 12'h000;
                else if (game_over)
                    base_p2 = {grey_p2, grey_p2, grey_p2};
                else
                    base_p2 = palette(cell_data);
                colour_p2 = (!empty_p2 && sprite_pixel[7:4] != 4'hF) ? shade(base_p2) : base_p2;
            end
        end
    end

    // Stage 3: registered colour outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_r <= 4'h0;
            vga_g <= 4'h0;
            vga_b <= 4'h0;
        end else begin
            vga_r <= colour_p2[11:8];
            vga_g <= colour_p2[7:4];
            vga_b <= colour_p2[3:0];
        end
    end

    // Flash animation; a start coinciding with frame_start does not count that frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            row_mask   <= '0;
            phase      <= 1'b0;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= FLASH;
                        row_mask   <= clear_rows;
                        phase      <= 1'b1;
                        frame_cnt  <= '0;
                        toggle_cnt <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                FLASH: begin
                    if (frame_start) begin
                        if (frame_cnt == FCNT_W'(FLASH_FRAMES - 1)) begin
                            frame_cnt  <= '0;
                            phase      <= ~phase;
                            toggle_cnt <= toggle_cnt + TCNT_W'(1);
                            if (toggle_cnt == TCNT_W'(FLASH_TOGGLES - 1)) begin
                                state      <= IDLE;
                                clear_busy <= 1'b0;
                                clear_done <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + FCNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            fade <= 4'd0;
        else if (!game_over)
            fade <= 4'd0;
        else if (frame_start)
            fade <= fade_step(fade);
    end

endmodule

// File: tb/tb_tetris_field_renderer.sv
// Directed bench for tetris_field_renderer: latency, regions, palette/shading,
// flash animation, game-over fade and reset abort.
module tb_tetris_field_renderer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] curr_x;
    logic [9:0]  curr_y;
    logic        active_area;
    logic        frame_start;
    logic [4:0]  cell_row;
    logic [3:0]  cell_col;
    logic [2:0]  cell_data;
    logic [3:0]  sprite_addr_x, sprite_addr_y;
    logic [11:0] sprite_pixel;
    logic        game_over;
    logic        clear_start;
    logic [19:0] clear_rows;
    logic        clear_busy, clear_done;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic [11:0] rgb;

    int checks = 0;
    int errors = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    always #5 clk = ~clk;

    tetris_field_renderer dut (
        .clk(clk), .rst_n(rst_n), .curr_x(curr_x), .curr_y(curr_y),
        .active_area(active_area), .frame_start(frame_start),
        .cell_row(cell_row), .cell_col(cell_col), .cell_data(cell_data),
        .sprite_addr_x(sprite_addr_x), .sprite_addr_y(sprite_addr_y),
        .sprite_pixel(sprite_pixel), .game_over(game_over),
        .clear_start(clear_start), .clear_rows(clear_rows),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pixel(input int x, input int y, input logic act);
        curr_x      = 11'(x);
        curr_y      = 10'(y);
        active_area = act;
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [3:0] g;
        logic       done_seen;

        rst_n = 1'b0; frame_start = 1'b0; game_over = 1'b0;
        clear_start = 1'b0; clear_rows = '0;
        cell_data = 3'd7; sprite_pixel = 12'hFFF;
        pixel(0, 0, 1'b0);
        tick(2);
        check("reset_rgb",  32'(rgb), 32'h000);
        check("reset_row",  32'(cell_row), 0);
        check("reset_col",  32'(cell_col), 0);
        check("reset_busy", 32'(clear_busy), 0);
        check("reset_done", 32'(clear_done), 0);
        rst_n = 1'b1;
        tick(1);

        // first cell: exact three-cycle latency
        cell_data = 3'd1; sprite_pixel = 12'h0F0;
        pixel(480, 80, 1'b1);
        tick(2);
        check("lat_t2_rgb", 32'(rgb), 32'h000);
        tick(1);
        check("lat_t3_rgb", 32'(rgb), 32'h0F0);
        check("first_row",  32'(cell_row), 2);
        check("first_col",  32'(cell_col), 0);
        check("first_spx",  32'(sprite_addr_x), 0);
        check("first_spy",  32'(sprite_addr_y), 0);
        cell_data = 3'd2;
        tick(1);
        check("pal_code2", 32'(rgb), 32'h00F);

        cell_data = 3'd6; sprite_pixel = 12'hFFF;
        pixel(500, 710, 1'b1);
        tick(3);
        check("addr_row_21", 32'(cell_row), 21);
        check("addr_col_0",  32'(cell_col), 0);
        check("addr_spx",    32'(sprite_addr_x), 10);
        check("addr_spy",    32'(sprite_addr_y), 11);
        check("pal_code6",   32'(rgb), 32'hFA0);

        pixel(799, 719, 1'b1);
        tick(3);
        check("corner_col", 32'(cell_col), 9);
        check("corner_spx", 32'(sprite_addr_x), 15);
        check("corner_spy", 32'(sprite_addr_y), 15);

        pixel(476, 100, 1'b1);
        tick(3);
        check("border_left", 32'(rgb), 32'hFFF);
        check("hold_row",    32'(cell_row), 21);
        check("hold_col",    32'(cell_col), 9);
        pixel(475, 100, 1'b1);
        tick(3);
        check("past_border", 32'(rgb), 32'h000);
        pixel(479, 79, 1'b1);
        tick(3);
        check("border_corner_neg", 32'(rgb), 32'hFFF);
        pixel(800, 719, 1'b1);
        tick(3);
        check("border_right", 32'(rgb), 32'hFFF);
        pixel(800, 724, 1'b1);
        tick(3);
        check("below_border", 32'(rgb), 32'h000);
        pixel(100, 100, 1'b1);
        tick(3);
        check("outside", 32'(rgb), 32'h000);
        pixel(480, 80, 1'b0);
        tick(3);
        check("inactive", 32'(rgb), 32'h000);

        // shading
        pixel(480, 80, 1'b1);
        cell_data = 3'd0; sprite_pixel = 12'h080;
        tick(3);
        check("shade_red", 32'(rgb), 32'h700);
        cell_data = 3'd6;
        tick(1);
        check("shade_orange", 32'(rgb), 32'h750);
        cell_data = 3'd7;
        tick(1);
        check("empty_dark", 32'(rgb), 32'h000);

        // flash on bottom row
        cell_data = 3'd0; sprite_pixel = 12'hFFF;
        pixel(500, 710, 1'b1);
        tick(3);
        check("pre_flash", 32'(rgb), 32'hF00);
        clear_rows = 20'h80000; clear_start = 1'b1;
        tick(1);
        clear_start = 1'b0; clear_rows = '0;
        check("busy_after_start", 32'(clear_busy), 1);
        tick(1);
        check("flash_white_f0", 32'(rgb), 32'hFFF);
        for (int n = 0; n < 7; n++) frame_pulse();
        check("flash_white_f7", 32'(rgb), 32'hFFF);
        frame_pulse();
        check("flash_normal_f8", 32'(rgb), 32'hF00);
        clear_start = 1'b1;
        tick(1);
        clear_start = 1'b0;
        tick(1);
        check("restart_ignored", 32'(rgb), 32'hF00);
        for (int n = 8; n < 16; n++) frame_pulse();
        check("flash_white_f16", 32'(rgb), 32'hFFF);
        pixel(500, 678, 1'b1);
        tick(3);
        check("unmasked_row", 32'(rgb), 32'hF00);
        pixel(500, 710, 1'b1);
        tick(3);
        check("mask_kept", 32'(rgb), 32'hFFF);
        for (int n = 16; n < 47; n++) frame_pulse();
        check("busy_f47", 32'(clear_busy), 1);
        check("done_f47", 32'(clear_done), 0);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        check("busy_end", 32'(clear_busy), 0);
        check("done_pulse", 32'(clear_done), 1);
        tick(1);
        check("done_once", 32'(clear_done), 0);
        check("post_flash", 32'(rgb), 32'hF00);

        // start and frame_start together: that frame is not counted
        clear_rows = 20'h80000; clear_start = 1'b1; frame_start = 1'b1;
        tick(1);
        clear_start = 1'b0; frame_start = 1'b0;
        tick(1);
        for (int n = 0; n < 7; n++) frame_pulse();
        check("coincident_f7", 32'(rgb), 32'hFFF);
        frame_pulse();
        check("coincident_f8", 32'(rgb), 32'hF00);

        // reset mid-flash
        rst_n = 1'b0;
        tick(1);
        check("rst_busy", 32'(clear_busy), 0);
        check("rst_rgb",  32'(rgb), 32'h000);
        check("rst_done", 32'(clear_done), 0);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (n % 2 == 0) frame_start = 1'b1; else frame_start = 1'b0;
            tick(1);
            if (clear_done) done_seen = 1'b1;
        end
        frame_start = 1'b0;
        check("no_done_after_rst", 32'(done_seen), 0);

        // game-over fade
        pixel(480, 80, 1'b1);
        cell_data = 3'd3; sprite_pixel = 12'hFFF;
        tick(3);
        check("pal_yellow", 32'(rgb), 32'hFF0);
        game_over = 1'b1;
        tick(1);
        check("grey_f0", 32'(rgb), 32'hFFF);
        for (int k = 1; k <= 12; k++) begin
            frame_pulse();
            g = 4'hF - ((k > 9) ? 4'd9 : 4'(k));
            check($sformatf("grey_f%0d", k), 32'(rgb), 32'({g, g, g}));
        end
        sprite_pixel = 12'h080;
        tick(1);
        check("grey_shaded", 32'(rgb), 32'h333);
        sprite_pixel = 12'hFFF;
        game_over = 1'b0;
        tick(1);
        check("gameover_drop", 32'(rgb), 32'hFF0);
        game_over = 1'b1;
        tick(1);
        check("fade_restart", 32'(rgb), 32'hFFF);
        game_over = 1'b0;
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
